// File: rtl/bus_cache_if.sv
// bus_cache_if: CPU-side and memory-side signals of the bus cache in one bundle.
// Latency: none, wires only.
// Backpressure: CPU holds sel_i until ack_o; the cache holds mem_sel_o until mem_ack_i.
interface bus_cache_if;
  // CPU side
  logic        flush_i;
  logic        sel_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  wr_mask_i;
  logic [31:0] data_in_i;
  logic [31:0] data_out_o;
  logic        ack_o;
  logic        busy_o;
  // memory side
  logic        mem_sel_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_wr_mask_o;
  logic [31:0] mem_data_out_o;
  logic [31:0] mem_data_in_i;
  logic        mem_ack_i;

  // the cache's view
  modport slave (
    input  flush_i, sel_i, addr_i, we_i, wr_mask_i, data_in_i, mem_data_in_i, mem_ack_i,
    output data_out_o, ack_o, busy_o, mem_sel_o, mem_addr_o, mem_we_o, mem_wr_mask_o,
           mem_data_out_o
  );

  // the view of the CPU plus memory surrounding the cache
  modport master (
    output flush_i, sel_i, addr_i, we_i, wr_mask_i, data_in_i, mem_data_in_i, mem_ack_i,
    input  data_out_o, ack_o, busy_o, mem_sel_o, mem_addr_o, mem_we_o, mem_wr_mask_o,
           mem_data_out_o
  );
endinterface

// File: rtl/bus_cache.sv
// bus_cache: direct-mapped, write-through, no-write-allocate cache, one 32-bit word per line.
// Latency: read hit acked 2 cycles after sel_i is sampled; misses, stores and uncached wait on memory.
// Backpressure: requests wait while busy_o (flush); at most one memory transaction outstanding.
// Optional feature macro: BUS_CACHE_STATS_EN adds hit_count_o / miss_count_o.
module bus_cache #(
  parameter int unsigned LINES         = 256,
  parameter logic [31:0] UNCACHED_BASE = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        reset_i,
`ifdef BUS_CACHE_STATS_EN
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o,
`endif
  bus_cache_if.slave  bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_UNC, S_DONE
  } state_t;

  state_t state, state_nxt;

  // latched request (word address only; byte offset is never needed after IDLE)
  logic [29:0]      req_word;
  logic             req_we;
  logic [3:0]       req_mask;
  logic [31:0]      req_data;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  // storage
  logic [LINES-1:0] valid;
  logic [31:0]      data_ram [LINES];
  logic [TAG_W-1:0] tag_ram  [LINES];
  logic [31:0]      rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] flush_idx;

  // control from the next-state logic
  logic             latch;
  logic             ram_we;
  logic [31:0]      ram_wdata;
  logic             fill;
  logic             clr_valid;
  logic             hit;
  logic             uncached;
  logic [31:0]      merged;

  // next values of the registered outputs
  logic        ack_nxt, msel_nxt, mwe_nxt, busy_nxt;
  logic [31:0] dout_nxt, maddr_nxt, mdata_nxt;
  logic [3:0]  mmask_nxt;

  assign req_idx  = req_word[IDX_W-1:0];
  assign req_tag  = req_word[29:IDX_W];
  assign hit      = valid[req_idx] && (rd_tag == req_tag);
  assign uncached = (bus.addr_i >= UNCACHED_BASE);
  // RAM reads are issued in IDLE from the live address so the word is ready in LOOKUP/WRITE
  assign rd_idx   = (state == S_IDLE) ? bus.addr_i[IDX_W+1:2] : req_idx;

  // byte-merge the store data into the resident word for a write hit
  always_comb begin
    merged = rd_data;
    for (int b = 0; b < 4; b++) begin
      if (req_mask[b]) merged[8*b +: 8] = req_data[8*b +: 8];
    end
  end

  // next state, next registered outputs and storage controls
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = merged;
    fill      = 1'b0;
    clr_valid = 1'b0;
    ack_nxt   = 1'b0;
    dout_nxt  = bus.data_out_o;
    msel_nxt  = bus.mem_sel_o;
    maddr_nxt = bus.mem_addr_o;
    mwe_nxt   = bus.mem_we_o;
    mmask_nxt = bus.mem_wr_mask_o;
    mdata_nxt = bus.mem_data_out_o;
    case (state)
      S_FLUSH: begin
        clr_valid = 1'b1;
        if (flush_idx == IDX_W'(LINES - 1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (bus.flush_i) begin
          state_nxt = S_FLUSH;
        end else if (bus.sel_i) begin
          latch = 1'b1;
          if (uncached || bus.we_i) begin
            state_nxt = uncached ? S_UNC : S_WRITE;
            msel_nxt  = 1'b1;
            mwe_nxt   = bus.we_i;
            maddr_nxt = bus.addr_i;
            mmask_nxt = bus.we_i ? bus.wr_mask_i : 4'b1111;
            mdata_nxt = bus.data_in_i;
          end else begin
            state_nxt = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          dout_nxt  = rd_data;
          ack_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          msel_nxt  = 1'b1;
          mwe_nxt   = 1'b0;
          maddr_nxt = {req_word, 2'b00};
          mmask_nxt = 4'b1111;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.mem_ack_i) begin
          ram_we    = 1'b1;
          ram_wdata = bus.mem_data_in_i;
          fill      = 1'b1;
          dout_nxt  = bus.mem_data_in_i;
          ack_nxt   = 1'b1;
          msel_nxt  = 1'b0;
          state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack_i) begin
          ram_we    = hit;
          ack_nxt   = 1'b1;
          msel_nxt  = 1'b0;
          mwe_nxt   = 1'b0;
          state_nxt = S_DONE;
        end
      end
      S_UNC: begin
        if (bus.mem_ack_i) begin
          if (!req_we) dout_nxt = bus.mem_data_in_i;
          ack_nxt   = 1'b1;
          msel_nxt  = 1'b0;
          mwe_nxt   = 1'b0;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    busy_nxt = (state_nxt == S_FLUSH);
  end

  // state, flush sweep index and registered outputs
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state              <= S_FLUSH;
      flush_idx          <= '0;
      bus.data_out_o     <= '0;
      bus.ack_o          <= 1'b0;
      bus.busy_o         <= 1'b0;
      bus.mem_sel_o      <= 1'b0;
      bus.mem_addr_o     <= '0;
      bus.mem_we_o       <= 1'b0;
      bus.mem_wr_mask_o  <= 4'b1111;
      bus.mem_data_out_o <= '0;
    end else begin
      state              <= state_nxt;
      bus.data_out_o     <= dout_nxt;
      bus.ack_o          <= ack_nxt;
      bus.busy_o         <= busy_nxt;
      bus.mem_sel_o      <= msel_nxt;
      bus.mem_addr_o     <= maddr_nxt;
      bus.mem_we_o       <= mwe_nxt;
      bus.mem_wr_mask_o  <= mmask_nxt;
      bus.mem_data_out_o <= mdata_nxt;
      // wraps back to 0 at the end of the sweep, ready for the next flush
      if (state == S_FLUSH) flush_idx <= flush_idx + 1'b1;
    end
  end

  // capture the CPU request when it is accepted in IDLE
  always_ff @(posedge clk) begin
    if (reset_i) begin
      req_word <= '0;
      req_we   <= 1'b0;
      req_mask <= '0;
      req_data <= '0;
    end else if (latch) begin
      req_word <= bus.addr_i[31:2];
      req_we   <= bus.we_i;
      req_mask <= bus.wr_mask_i;
      req_data <= bus.data_in_i;
    end
  end

  // synchronous-read data and tag RAMs
  always_ff @(posedge clk) begin
    rd_data <= data_ram[rd_idx];
    rd_tag  <= tag_ram[rd_idx];
    if (ram_we) data_ram[req_idx] <= ram_wdata;
    if (fill)   tag_ram[req_idx]  <= req_tag;
  end

  // valid bits: no reset needed, reset always enters the flush sweep
  always_ff @(posedge clk) begin
    if (clr_valid)  valid[flush_idx] <= 1'b0;
    else if (fill)  valid[req_idx]   <= 1'b1;
  end

`ifdef BUS_CACHE_STATS_EN
  // count LOOKUP outcomes only; counters survive a flush
  always_ff @(posedge clk) begin
    if (reset_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) hit_count_o  <= hit_count_o + 32'd1;
      else     miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bus_cache.sv
// tb_bus_cache: directed stimulus against a slot-level cache model and a bench-owned memory.
// Latency: memory answers mem_sel_o after a programmable number of cycles.
// Backpressure: CPU side holds sel until ack, then drops it one edge later.
module tb_bus_cache;
  localparam int LINES = 256;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bus_cache_if bif ();

`ifdef BUS_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  bus_cache #(.LINES(LINES), .UNCACHED_BASE(32'hF000_0000)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
`ifdef BUS_CACHE_STATS_EN
    .hit_count_o (hit_count),
    .miss_count_o(miss_count),
`endif
    .bus         (bif)
  );

  int compares = 0;
  int errors   = 0;

  // bench memory: explicitly written words, otherwise a fixed address pattern
  logic [31:0] mem_words [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // cache model: which word address occupies each slot, and its contents
  logic [29:0] m_word [int];
  logic [31:0] m_data [int];
  int m_hits = 0;
  int m_misses = 0;

  typedef struct {logic [31:0] addr; logic we; logic [3:0] mask; logic [31:0] data;} mem_tx_t;
  mem_tx_t mem_log[$];
  typedef struct {bit is_read; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t cmp_e;
  int mem_lat = 3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // memory responder
  initial begin : responder
    int cnt;
    logic [31:0] w;
    mem_tx_t t;
    cnt = 0;
    bif.mem_ack_i = 1'b0;
    bif.mem_data_in_i = '0;
    forever begin
      @(posedge clk); #1;
      bif.mem_ack_i = 1'b0;
      if (reset_i || !bif.mem_sel_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          t.addr = bif.mem_addr_o; t.we = bif.mem_we_o;
          t.mask = bif.mem_wr_mask_o; t.data = bif.mem_data_out_o;
          mem_log.push_back(t);
          if (t.we) begin
            w = merge(mem_rd(t.addr), t.data, t.mask);
            mem_words[t.addr] = w;
          end else begin
            bif.mem_data_in_i = mem_rd(t.addr);
          end
          bif.mem_ack_i = 1'b1;
        end
      end
    end
  end

  // compare process: every ack must match a pending request; no memory traffic while busy
  always @(negedge clk) begin
    if (!reset_i) begin
      if (bif.busy_o) begin
        compares++;
        if (bif.mem_sel_o) begin
          errors++;
          $display("FAIL sel_during_flush: mem_sel_o=%b want 0", bif.mem_sel_o);
        end
      end
      if (bif.ack_o) begin
        compares++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack_o=1 want 0 (no request pending)");
        end else begin
          cmp_e = exp_q.pop_front();
          if (cmp_e.is_read && bif.data_out_o !== cmp_e.data) begin
            errors++;
            $display("FAIL ack_data: got %h want %h", bif.data_out_o, cmp_e.data);
          end
        end
      end
    end
  end

  task automatic model_clear();
    m_word.delete();
    m_data.delete();
  endtask

  task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] m,
                        input logic [31:0] d, input bit with_flush,
                        output logic [31:0] rdata, output int cycles, output int busy_cycles);
    bit unc, resident, exp_mem, got;
    logic [31:0] exp_rd;
    int idx, n0;
    exp_t e;
    mem_tx_t t;
    if (with_flush) model_clear();
    idx = int'(a[31:2]) % LINES;
    unc = (a >= 32'hF000_0000);
    resident = !unc && m_word.exists(idx) && (m_word[idx] == a[31:2]);
    exp_mem = 1'b1;
    exp_rd = '0;
    if (unc) begin
      if (!we) exp_rd = mem_rd(a);
    end else if (we) begin
      if (resident) m_data[idx] = merge(m_data[idx], d, m);
    end else if (resident) begin
      exp_mem = 1'b0; exp_rd = m_data[idx]; m_hits++;
    end else begin
      exp_rd = mem_rd(a); m_word[idx] = a[31:2]; m_data[idx] = exp_rd; m_misses++;
    end
    e.is_read = !we; e.data = exp_rd;
    exp_q.push_back(e);
    n0 = mem_log.size();

    @(posedge clk); #1;
    bif.addr_i = a; bif.we_i = we; bif.wr_mask_i = m; bif.data_in_i = d;
    bif.sel_i = 1'b1; bif.flush_i = with_flush;
    cycles = 0; busy_cycles = 0; rdata = '0; got = 1'b0;
    while (!got && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      bif.flush_i = 1'b0;
      if (bif.busy_o) busy_cycles++;
      if (bif.ack_o) begin got = 1'b1; rdata = bif.data_out_o; end
    end
    chk("req_acked", 32'(got), 32'd1);
    if (!got) begin
      bif.sel_i = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(bif.ack_o), 32'd0);
    bif.sel_i = 1'b0;
    chk("mem_tx_count", 32'(mem_log.size() - n0), 32'(exp_mem));
    if (exp_mem && mem_log.size() > n0) begin
      t = mem_log[n0];
      chk("mem_tx_addr", t.addr, a);
      chk("mem_tx_we", 32'(t.we), 32'(we));
      chk("mem_tx_mask", 32'(t.mask), we ? 32'(m) : 32'hF);
      if (we) chk("mem_tx_data", t.data, d);
    end
    if (!exp_mem) chk("hit_latency", 32'(cycles), 32'd2);
  endtask

  task automatic wait_flush();
    bit seen, done;
    seen = 1'b0; done = 1'b0;
    for (int n = 0; n < 3 * LINES && !done; n++) begin
      @(posedge clk); #1;
      if (bif.busy_o) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk("flush_completes", 32'(done), 32'd1);
  endtask

  task automatic check_stats(input string nm);
`ifdef BUS_CACHE_STATS_EN
    chk({nm, "_hits"}, hit_count, 32'(m_hits));
    chk({nm, "_misses"}, miss_count, 32'(m_misses));
`else
    if (nm.len() == 0) $display("check_stats: empty tag");
`endif
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    int cyc, bcyc, n0;
    bit got;
    reset_i = 1'b1;
    bif.sel_i = 1'b0; bif.flush_i = 1'b0; bif.addr_i = '0;
    bif.we_i = 1'b0; bif.wr_mask_i = '0; bif.data_in_i = '0;
    mem_words[32'h100] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", bif.data_out_o, 32'h0);
    chk("rst_ack", 32'(bif.ack_o), 32'd0);
    chk("rst_mem_sel", 32'(bif.mem_sel_o), 32'd0);
    chk("rst_mem_addr", bif.mem_addr_o, 32'h0);
    chk("rst_mem_we", 32'(bif.mem_we_o), 32'd0);
    chk("rst_mem_mask", 32'(bif.mem_wr_mask_o), 32'hF);
    chk("rst_mem_data", bif.mem_data_out_o, 32'h0);
    chk("rst_busy", 32'(bif.busy_o), 32'd0);
    check_stats("rst");
    reset_i = 1'b0;
    wait_flush();

    // cold read miss, then hit
    do_req(32'h100, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t1_miss_data", rd, 32'hDEADBEEF);
    do_req(32'h100, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t1_hit_data", rd, 32'hDEADBEEF);
    chk("t1_hit_cycles", 32'(cyc), 32'd2);

    // byte write on a resident line, then hit returns merged word
    do_req(32'h100, 1'b1, 4'b0010, 32'h0000AA00, 1'b0, rd, cyc, bcyc);
    do_req(32'h100, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t2_merged_hit", rd, 32'hDEADAAEF);
    check_stats("t2");

    // write to a non-resident line does not allocate
    do_req(32'h200, 1'b1, 4'hF, 32'h12345678, 1'b0, rd, cyc, bcyc);
    do_req(32'h200, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t3_read_after_write", rd, 32'h12345678);
    chk("t3_was_miss", 32'(cyc > 2), 32'd1);

    // conflicting tags on the same slot evict each other
    do_req(32'h100, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    do_req(32'h100 + 4 * LINES, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t4_alias_data", rd, 32'hA5A5_0500);
    do_req(32'h100, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t4_evicted_data", rd, 32'hDEADAAEF);
    chk("t4_evicted_miss", 32'(cyc > 2), 32'd1);

    // uncached reads always go to memory and are not counted
    check_stats("t5_before");
    do_req(32'hF000_0010, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    do_req(32'hF000_0010, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t5_unc_data", rd, 32'h55A5_0010);
    check_stats("t5_after");

    // flush wins over a simultaneous request; request then served as a miss
    do_req(32'h100, 1'b0, 4'h0, 32'h0, 1'b1, rd, cyc, bcyc);
    chk("t6_busy_cycles", 32'(bcyc), 32'(LINES));
    chk("t6_data", rd, 32'hDEADAAEF);
    check_stats("t6");

    // reset during FILL abandons the transaction
    n0 = mem_log.size();
    mem_lat = 20;
    @(posedge clk); #1;
    bif.addr_i = 32'h300; bif.we_i = 1'b0; bif.sel_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bif.mem_sel_o) got = 1'b1;
    end
    chk("t7_fill_started", 32'(got), 32'd1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    chk("t7_mem_sel_dropped", 32'(bif.mem_sel_o), 32'd0);
    chk("t7_no_ack", 32'(bif.ack_o), 32'd0);
    bif.sel_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0; mem_lat = 3;
    wait_flush();
    chk("t7_no_mem_tx", 32'(mem_log.size() - n0), 32'd0);
    check_stats("t7_after_reset");
    do_req(32'h300, 1'b0, 4'h0, 32'h0, 1'b0, rd, cyc, bcyc);
    chk("t7_read_after_reset", rd, 32'hA5A5_0300);
    chk("t7_pending_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end
endmodule
